// File: rtl/mmio_bridge_pkg.sv
// mmio_bridge_pkg: shared decode constants and types
// for the cpu-side MMIO bridge.
package mmio_bridge_pkg;

  typedef enum logic {
    SEL_RAM = 1'b0,
    SEL_IO  = 1'b1
  } sel_e;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_UART = 18'h30000;
  localparam logic [17:0] IO_CLK  = 18'h30004;
  localparam logic [17:0] IO_CLK1 = 18'h30005;
  localparam logic [17:0] IO_CLK2 = 18'h30006;
  localparam logic [17:0] IO_CLK3 = 18'h30007;

  function automatic logic is_io(
    input logic [17:0] a
  );
    return a[17:16] == IO_BASE[17:16];
  endfunction

endpackage

// File: rtl/mmio_bridge_fifo.sv
// byte_fifo: power-of-two byte queue holding the
// UART TX stream; push and pop may share a cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    push,
  input  logic                    pop,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  count_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P1 = AW'(1);
  localparam logic [AW:0] C1 = (AW+1)'(1);
  localparam logic [AW:0] CMAX = (AW+1)'(DEPTH);

  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == CMAX;
    do_pop = pop & ~empty;
    // a pop frees the slot a full-queue push lands in
    do_push = push & (~full | do_pop);
    wr_d = do_push ? wr_q + P1 : wr_q;
    rd_d = do_pop ? rd_q + P1 : rd_q;
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10: cnt_d = cnt_q + C1;
      2'b01: cnt_d = cnt_q - C1;
      default: ;
    endcase
    dout = mem_q[rd_q];
    count = cnt_q;
    count_nxt = cnt_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: cpu byte-bus decode to RAM or I/O,
// UART TX queue, RX pop, cycle counter and halt flag.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2,
  parameter int CNT_W       = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic        ram_en,
  output logic        ram_wr,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        prog_done
);

  localparam int CW = $clog2(TX_DEPTH);
  localparam logic [CNT_W-1:0] T1 = CNT_W'(1);

  logic [17:0] a;
  logic acc, io, rd_io, wr_io;
  logic push, pop, empty, full;
  logic [7:0] fifo_din, fifo_dout;
  logic [CW:0] cnt, cnt_nx;

  sel_e sel_q, sel_d;
  logic [7:0] rd_q, rd_d;
  logic [31:0] snap_q, snap_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic halt_q, halt_d;
  logic done_q, done_d;
  logic bfull_q, bfull_d;
  logic unused_ok;

  assign a = cpu_a[17:0];
  assign unused_ok = ^{cpu_a[31:18], cnt, full};

  byte_fifo #(
    .DEPTH(TX_DEPTH)
  ) u_txq (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (push),
    .pop      (pop),
    .din      (fifo_din),
    .dout     (fifo_dout),
    .empty    (empty),
    .full     (full),
    .count    (cnt),
    .count_nxt(cnt_nx)
  );

  always_comb begin
    acc = rdy_in & ~rst_in;
    io = is_io(a);
    rd_io = acc & io & ~cpu_wr;
    wr_io = acc & io & cpu_wr;

    ram_en = acc & ~io;
    ram_wr = ram_en & cpu_wr;
    ram_a = a[16:0];
    ram_dout = cpu_dout;

    rx_pop = rd_io & (a == IO_UART) & rx_valid;
    pop = ~empty & tx_ready;

    push = 1'b0;
    fifo_din = cpu_dout;
    halt_d = halt_q;
    if (wr_io & ~halt_q) begin
      unique case (1'b1)
        a == IO_UART: push = cpu_dout != 8'h00;
        a == IO_CLK: begin
          // terminator bypasses the zero filter
          push = 1'b1;
          fifo_din = 8'h00;
          halt_d = 1'b1;
        end
        default: ;
      endcase
    end

    sel_d = sel_q;
    rd_d = rd_q;
    snap_d = snap_q;
    if (acc) sel_d = io ? SEL_IO : SEL_RAM;
    if (rd_io) begin
      unique case (1'b1)
        a == IO_UART:
          rd_d = rx_valid ? rx_data : 8'h00;
        a == IO_CLK: begin
          snap_d = 32'(tick_q);
          rd_d = tick_q[7:0];
        end
        a == IO_CLK1: rd_d = snap_q[15:8];
        a == IO_CLK2: rd_d = snap_q[23:16];
        a == IO_CLK3: rd_d = snap_q[31:24];
        default: rd_d = 8'h00;
      endcase
    end

    tick_d = tick_q + T1;
    done_d = done_q | (halt_q & empty & ~pop);
    // next-state count so the flag leads in-flight writes
    bfull_d =
      (TX_DEPTH - int'(cnt_nx)) <= FULL_MARGIN;

    cpu_din = (sel_q == SEL_RAM) ? ram_din : rd_q;
    tx_data = fifo_dout;
    tx_valid = ~empty;
    prog_done = done_q;
    io_buffer_full = bfull_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_q <= SEL_RAM;
      rd_q <= '0;
      snap_q <= '0;
      tick_q <= '0;
      halt_q <= 1'b0;
      done_q <= 1'b0;
      bfull_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      rd_q <= rd_d;
      snap_q <= snap_d;
      tick_q <= tick_d;
      halt_q <= halt_d;
      done_q <= done_d;
      bfull_q <= bfull_d;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed self-checking bench for
// mmio_bridge with a 1-cycle RAM model.
module tb_mmio_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [31:0] cpu_a = '0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic        ram_en;
  logic        ram_wr;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic        prog_done;

  int checks = 0;
  int failures = 0;
  logic [31:0] cyc;
  logic [7:0] ram_m [0:131071];

  mmio_bridge #(
    .TX_DEPTH   (16),
    .FULL_MARGIN(2),
    .CNT_W      (32)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .cpu_a         (cpu_a),
    .cpu_wr        (cpu_wr),
    .cpu_dout      (cpu_dout),
    .cpu_din       (cpu_din),
    .io_buffer_full(io_buffer_full),
    .ram_en        (ram_en),
    .ram_wr        (ram_wr),
    .ram_a         (ram_a),
    .ram_dout      (ram_dout),
    .ram_din       (ram_din),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_pop        (rx_pop),
    .prog_done     (prog_done)
  );

  always #5 clk_in = ~clk_in;

  // RAM model and reference cycle count
  always @(posedge clk_in) begin
    if (rst_in) begin
      cyc <= '0;
      ram_din <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (ram_en) begin
        if (ram_wr) ram_m[ram_a] <= ram_dout;
        ram_din <= ram_m[ram_a];
      end
    end
  end

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus(
    input logic [31:0] ad,
    input logic w,
    input logic [7:0] d
  );
    cpu_a = ad;
    cpu_wr = w;
    cpu_dout = d;
  endtask

  task automatic idle;
    bus(32'h0, 1'b0, 8'h00);
  endtask

  task automatic io_wr(
    input logic [31:0] ad,
    input logic [7:0] d
  );
    bus(ad, 1'b1, d);
    step();
    idle();
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    step();
    step();
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_tx_valid got %b want 0", tx_valid);
    end
    checks++;
    if (prog_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_prog_done got %b want 0", prog_done);
    end
    checks++;
    if (io_buffer_full !== 1'b0) begin
      failures++;
      $display("FAIL rst_full got %b want 0", io_buffer_full);
    end
    checks++;
    if (ram_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_ram_en got %b want 0", ram_en);
    end
    checks++;
    if (cpu_din !== 8'h00) begin
      failures++;
      $display("FAIL rst_cpu_din got %h want 00", cpu_din);
    end
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_ram;
    bus(32'h0000_0100, 1'b1, 8'h55);
    #1;
    checks++;
    if ({ram_en, ram_wr, ram_a, ram_dout} !==
        {1'b1, 1'b1, 17'h00100, 8'h55}) begin
      failures++;
      $display("FAIL ram_wr_strobe got %b%b %h %h want 11 00100 55",
               ram_en, ram_wr, ram_a, ram_dout);
    end
    step();
    bus(32'h0000_0100, 1'b0, 8'h00);
    #1;
    checks++;
    if ({ram_en, ram_wr} !== 2'b10) begin
      failures++;
      $display("FAIL ram_rd_strobe got %b%b want 10", ram_en, ram_wr);
    end
    step();
    idle();
    checks++;
    if (cpu_din !== 8'h55) begin
      failures++;
      $display("FAIL ram_read got %h want 55", cpu_din);
    end
    checks++;
    if ({tx_valid, rx_pop} !== 2'b00) begin
      failures++;
      $display("FAIL ram_side_effects got %b%b want 00", tx_valid, rx_pop);
    end
  endtask

  task automatic test_tx;
    tx_ready = 1'b0;
    io_wr(32'h0003_0000, 8'h41);
    io_wr(32'h0003_0000, 8'h00);
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h41}) begin
      failures++;
      $display("FAIL tx_head got %b %h want 1 41", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    step();
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL tx_zero_dropped got %b want 0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_pressure;
    logic [7:0] exp;
    tx_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      io_wr(32'h0003_0000, 8'h10 + 8'(i));
      if (i == 12) begin
        checks++;
        if (io_buffer_full !== 1'b0) begin
          failures++;
          $display("FAIL bp_13 got %b want 0", io_buffer_full);
        end
      end
    end
    checks++;
    if (io_buffer_full !== 1'b1) begin
      failures++;
      $display("FAIL bp_14 got %b want 1", io_buffer_full);
    end
    for (int i = 0; i < 3; i++)
      io_wr(32'h0003_0000, 8'h80 + 8'(i));
    checks++;
    if (io_buffer_full !== 1'b1) begin
      failures++;
      $display("FAIL bp_17 got %b want 1", io_buffer_full);
    end
    tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp = (k < 14) ? 8'h10 + 8'(k) : 8'h80 + 8'(k - 14);
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, exp}) begin
        failures++;
        $display("FAIL bp_drain%0d got %b %h want 1 %h",
                 k, tx_valid, tx_data, exp);
      end
      step();
    end
    checks++;
    if ({tx_valid, io_buffer_full} !== 2'b00) begin
      failures++;
      $display("FAIL bp_empty got %b%b want 00",
               tx_valid, io_buffer_full);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_clock;
    logic [31:0] e;
    rdy_in = 1'b0;
    bus(32'h0003_0004, 1'b0, 8'h00);
    repeat (5) step();
    rdy_in = 1'b1;
    e = cyc;
    step();
    checks++;
    if (cpu_din !== e[7:0]) begin
      failures++;
      $display("FAIL clk_b0 got %h want %h", cpu_din, e[7:0]);
    end
    bus(32'h0003_0005, 1'b0, 8'h00);
    step();
    checks++;
    if (cpu_din !== e[15:8]) begin
      failures++;
      $display("FAIL clk_b1 got %h want %h", cpu_din, e[15:8]);
    end
    bus(32'h0003_0006, 1'b0, 8'h00);
    step();
    checks++;
    if (cpu_din !== e[23:16]) begin
      failures++;
      $display("FAIL clk_b2 got %h want %h", cpu_din, e[23:16]);
    end
    bus(32'h0003_0007, 1'b0, 8'h00);
    step();
    checks++;
    if (cpu_din !== e[31:24]) begin
      failures++;
      $display("FAIL clk_b3 got %h want %h", cpu_din, e[31:24]);
    end
    idle();
    repeat (300) step();
    bus(32'h0003_0005, 1'b0, 8'h00);
    step();
    checks++;
    if (cpu_din !== e[15:8]) begin
      failures++;
      $display("FAIL clk_snap_held got %h want %h", cpu_din, e[15:8]);
    end
    bus(32'h0003_0008, 1'b0, 8'h00);
    step();
    checks++;
    if (cpu_din !== 8'h00) begin
      failures++;
      $display("FAIL io_unmapped got %h want 00", cpu_din);
    end
    idle();
  endtask

  task automatic test_rx;
    rx_valid = 1'b1;
    rx_data = 8'h31;
    bus(32'h0003_0000, 1'b0, 8'h00);
    #1;
    checks++;
    if (rx_pop !== 1'b1) begin
      failures++;
      $display("FAIL rx_pop got %b want 1", rx_pop);
    end
    step();
    checks++;
    if (cpu_din !== 8'h31) begin
      failures++;
      $display("FAIL rx_data got %h want 31", cpu_din);
    end
    rdy_in = 1'b0;
    rx_data = 8'h99;
    #1;
    checks++;
    if (rx_pop !== 1'b0) begin
      failures++;
      $display("FAIL rx_pop_nordy got %b want 0", rx_pop);
    end
    step();
    checks++;
    if (cpu_din !== 8'h31) begin
      failures++;
      $display("FAIL rx_hold_nordy got %h want 31", cpu_din);
    end
    rdy_in = 1'b1;
    rx_valid = 1'b0;
    #1;
    checks++;
    if (rx_pop !== 1'b0) begin
      failures++;
      $display("FAIL rx_pop_empty got %b want 0", rx_pop);
    end
    step();
    checks++;
    if (cpu_din !== 8'h00) begin
      failures++;
      $display("FAIL rx_empty got %h want 00", cpu_din);
    end
    idle();
  endtask

  task automatic test_halt;
    tx_ready = 1'b0;
    io_wr(32'h0003_0000, 8'h78);
    io_wr(32'h0003_0004, 8'h55);
    io_wr(32'h0003_0000, 8'h79);
    checks++;
    if ({tx_valid, tx_data, prog_done} !==
        {1'b1, 8'h78, 1'b0}) begin
      failures++;
      $display("FAIL halt_head got %b %h %b want 1 78 0",
               tx_valid, tx_data, prog_done);
    end
    tx_ready = 1'b1;
    step();
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h00}) begin
      failures++;
      $display("FAIL halt_term got %b %h want 1 00",
               tx_valid, tx_data);
    end
    step();
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_ignored got %b want 0", tx_valid);
    end
    for (int i = 0; i < 4 && !prog_done; i++) step();
    checks++;
    if (prog_done !== 1'b1) begin
      failures++;
      $display("FAIL halt_done got %b want 1", prog_done);
    end
    repeat (3) step();
    checks++;
    if (prog_done !== 1'b1) begin
      failures++;
      $display("FAIL halt_sticky got %b want 1", prog_done);
    end

    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    tx_ready = 1'b0;
    io_wr(32'h0003_0000, 8'h61);
    io_wr(32'h0003_0000, 8'h62);
    io_wr(32'h0003_0004, 8'h00);
    tx_ready = 1'b1;
    step();
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h62}) begin
      failures++;
      $display("FAIL mid_drain got %b %h want 1 62",
               tx_valid, tx_data);
    end
    bus(32'h0003_0004, 1'b0, 8'h00);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    tx_ready = 1'b0;
    idle();
    checks++;
    if ({tx_valid, prog_done, io_buffer_full} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid got %b%b%b want 000",
               tx_valid, prog_done, io_buffer_full);
    end
    checks++;
    if (cpu_din !== 8'h00) begin
      failures++;
      $display("FAIL rst_pending_rd got %h want 00", cpu_din);
    end
    io_wr(32'h0003_0000, 8'h7a);
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h7a}) begin
      failures++;
      $display("FAIL rst_halt_clr got %b %h want 1 7a",
               tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({tx_valid, prog_done} !== 2'b00) begin
      failures++;
      $display("FAIL rst_no_done got %b%b want 00",
               tx_valid, prog_done);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ram();
    test_tx();
    test_back_pressure();
    test_clock();
    test_rx();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
